fifo_pack_gearbox: RTL

// - Upstream feeder for the BRAM FIFO. Packs a stream of narrow beats into wide FIFO entries.
// - Each entry holds N_RATIO beats, or fewer when a packet ends early on in_last.
// - Writes each entry with a single enq pulse, gated by the FIFO's almostFull.
// - Sits between a narrow producer (valid/ready) and the fifo_bram enq side.
//

---
 rtl/fifo_pack_gearbox_pkg.sv | 20 ++
 rtl/fifo_pack_gearbox_if.sv | 36 +++
 rtl/fifo_pack_gearbox.sv | 98 +++++++++
 3 files changed

// File: rtl/fifo_pack_gearbox_pkg.sv
// Shared definitions for the narrow-to-wide FIFO packer and its downstream
// unpacker.
//   pack_cnt_bits(n) : width of a beat counter that can hold 0..n
//   t_pack_meta      : per-entry metadata {count, last} stored beside the data
package fifo_pack_pkg;

    function automatic int pack_cnt_bits(input int n);
        return $clog2(n + 1);
    endfunction

    // Metadata layout sized for the default ratio of 8 beats per entry.
    localparam int PACK_META_RATIO    = 8;
    localparam int PACK_META_CNT_BITS = pack_cnt_bits(PACK_META_RATIO);

    typedef struct packed {
        logic [PACK_META_CNT_BITS-1:0] count;
        logic                          last;
    } t_pack_meta;

endpackage

// File: rtl/fifo_pack_gearbox_if.sv
// Bundle of the producer stream and FIFO enqueue signals around the packer.
//   in_data/in_valid/in_last/in_ready : narrow beat stream (valid/ready)
//   out_data/out_count/out_last       : packed entry toward the FIFO
//   out_en                            : enqueue strobe
//   out_almostFull                    : FIFO back-pressure
// master = environment side (producer + FIFO), slave = the packer.
interface fifo_pack_gearbox_if #(
    parameter int N_IN_BITS = 64,
    parameter int N_RATIO   = 8
);
    import fifo_pack_pkg::*;

    localparam int N_OUT_BITS = N_IN_BITS * N_RATIO;
    localparam int N_CNT_BITS = pack_cnt_bits(N_RATIO);

    logic [N_IN_BITS-1:0]  in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [N_OUT_BITS-1:0] out_data;
    logic [N_CNT_BITS-1:0] out_count;
    logic                  out_last;
    logic                  out_en;
    logic                  out_almostFull;

    modport master (
        output in_data, in_valid, in_last, out_almostFull,
        input  in_ready, out_data, out_count, out_last, out_en
    );

    modport slave (
        input  in_data, in_valid, in_last, out_almostFull,
        output in_ready, out_data, out_count, out_last, out_en
    );

endinterface

// File: rtl/fifo_pack_gearbox.sv
// Packs N_RATIO narrow beats (or fewer, when in_last arrives early) into one
// wide FIFO entry and writes it with a single out_en pulse, honouring the
// FIFO's almostFull.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : fifo_pack_gearbox_if.slave (beat stream in, FIFO enqueue out)
module fifo_pack_gearbox
    import fifo_pack_pkg::*;
#(
    parameter int N_IN_BITS = 64,
    parameter int N_RATIO   = 8
) (
    input  logic               clk,
    input  logic               reset,
    fifo_pack_gearbox_if.slave bus
);

    localparam int N_OUT_BITS = N_IN_BITS * N_RATIO;
    localparam int N_CNT_BITS = pack_cnt_bits(N_RATIO);

    logic [N_OUT_BITS-1:0] asm_data;
    logic [N_CNT_BITS-1:0] asm_cnt;
    logic [N_OUT_BITS-1:0] next_data;

    logic                  emit_valid;
    logic [N_OUT_BITS-1:0] emit_data;
    logic [N_CNT_BITS-1:0] emit_count;
    logic                  emit_last;

    logic                  out_en;
    logic                  accept;
    logic                  entry_done;

    // Drain and refill may coincide: when the held entry leaves this cycle
    // the packer can already accept the beat that completes the next one.
    assign out_en       = emit_valid && !bus.out_almostFull;
    assign bus.in_ready = !reset && !(emit_valid && bus.out_almostFull);
    assign accept       = bus.in_valid && bus.in_ready;
    assign entry_done   = bus.in_last || (asm_cnt == N_CNT_BITS'(N_RATIO - 1));

    // Assembly data with the incoming beat merged in. Slots above the new
    // beat still hold beats of an earlier entry and are cleared here, so a
    // short entry leaves the packer zero-padded.
    always_comb begin
        next_data = '0;
        for (int k = 0; k < N_RATIO; k++) begin
            if (k < int'(asm_cnt))
                next_data[k*N_IN_BITS +: N_IN_BITS] = asm_data[k*N_IN_BITS +: N_IN_BITS];
            else if (k == int'(asm_cnt))
                next_data[k*N_IN_BITS +: N_IN_BITS] = bus.in_data;
        end
    end

    // Assembly data: only slots below asm_cnt are ever read, so no reset.
    always_ff @(posedge clk) begin
        if (accept)
            asm_data <= next_data;
    end

    // Assembly counter and emit register
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_cnt    <= '0;
            emit_valid <= 1'b0;
            emit_data  <= '0;
            emit_count <= '0;
            emit_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (entry_done) begin
                    asm_cnt    <= '0;
                    emit_data  <= next_data;
                    emit_count <= asm_cnt + 1'b1;
                    emit_last  <= bus.in_last;
                end else begin
                    asm_cnt <= asm_cnt + 1'b1;
                end
            end

            if (accept && entry_done)
                emit_valid <= 1'b1;
            else if (out_en)
                emit_valid <= 1'b0;
        end
    end

    assign bus.out_en    = out_en;
    assign bus.out_data  = emit_data;
    assign bus.out_count = emit_count;
    assign bus.out_last  = emit_last;

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        out_en |-> !bus.out_almostFull);
    a_count_nonzero : assert property (@(posedge clk) disable iff (reset)
        out_en |-> (emit_count != '0));

endmodule
